// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg -- shared constants for the scoreboarded register file.
//
// Contents:
//   XLEN_DEFAULT / NREG_DEFAULT / NRP_DEFAULT : default width, register count
//                                               and read-port count
//   abi_reg_e                                 : RISC-V ABI register names
//                                               (zero=0, ra=1 .. t6=31)
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 32;
  localparam int NRP_DEFAULT  = 2;

  typedef enum logic [4:0] {
    zero = 5'd0,
    ra   = 5'd1,
    sp, gp, tp,
    t0, t1, t2,
    s0, s1,
    a0, a1, a2, a3, a4, a5, a6, a7,
    s2, s3, s4, s5, s6, s7, s8, s9, s10, s11,
    t3, t4, t5, t6
  } abi_reg_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard -- per-register "load outstanding" tracking.
//
// Ports:
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   ld_issue, ld_rd : a load was issued to the bus, and its destination register
//   ld_wr, ld_addr  : a load has returned to ld_addr
//   flush           : drop every outstanding load
//   busy            : registered busy vector (bit 0 is always 0)
//   busy_cnt        : registered popcount of busy
//   issue_err       : registered one-cycle pulse after an issue to a register
//                     that already had a load outstanding
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG),
  localparam int CW = $clog2(NREG + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_issue,
  input  logic [AW-1:0]   ld_rd,
  input  logic            ld_wr,
  input  logic [AW-1:0]   ld_addr,
  input  logic            flush,
  output logic [NREG-1:0] busy,
  output logic [CW-1:0]   busy_cnt,
  output logic            issue_err
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic ret_valid;
  logic iss_valid;

  assign ret_valid = ld_wr    && (ld_addr != '0);
  assign iss_valid = ld_issue && (ld_rd   != '0);

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    busy_d = busy_q;
    err_d  = 1'b0;

    if (ret_valid) begin
      busy_d[ld_addr] = 1'b0;
    end

    // A register whose load returns this same cycle is free for a new issue;
    // the new load then owns the busy bit.
    if (iss_valid) begin
      if (busy_q[ld_rd] && !(ret_valid && (ld_addr == ld_rd))) begin
        err_d = 1'b1;
      end else begin
        busy_d[ld_rd] = 1'b1;
      end
    end

    // Flush wins over everything, including a same-cycle issue; the dropped
    // issue is not reported as an error.
    if (flush) begin
      busy_d = '0;
      err_d  = 1'b0;
    end

    busy_d[0] = 1'b0;

    cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_d = cnt_d + CW'(busy_d[i]);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign busy      = busy_q;
  assign busy_cnt  = cnt_q;
  assign issue_err = err_q;

endmodule

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb -- register file with two write ports and a load scoreboard.
//
// Parameters: XLEN (register width), NREG (16 or 32 registers), NRP (2..4
//             read ports). AW = $clog2(NREG).
// Ports:
//   clk, rst                        : rising-edge clock, async active-high reset
//   i_rs_addr / o_rs_data / o_rs_busy : packed read ports (port p at p*AW,
//                                     p*XLEN, bit p), combinational
//   i_wb_wr / i_wb_addr / i_wb_data : ALU writeback (wins on address clash)
//   i_ld_wr / i_ld_addr / i_ld_data : load-return writeback, clears busy
//   i_ld_issue / i_ld_rd            : load issued, sets busy on rd
//   i_flush                         : clear all busy bits
//   o_busy_cnt                      : number of busy registers (registered)
//   o_issue_err                     : one-cycle pulse after an illegal issue
//
// Build option: define REGFILE_SB_BYPASS_EN to forward same-cycle write data
// (i_wb over i_ld) to the read ports and to show a returning register as not
// busy. Without it, reads see only stored state.
// Register 0 reads as zero, is never busy, and ignores writes and issues.
// -----------------------------------------------------------------------------
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = NREG_DEFAULT,
  parameter int NRP  = NRP_DEFAULT,
  localparam int AW = $clog2(NREG),
  localparam int CW = $clog2(NREG + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRP*AW-1:0] i_rs_addr,
  output logic [NRP*XLEN-1:0] o_rs_data,
  output logic [NRP-1:0]    o_rs_busy,
  input  logic              i_wb_wr,
  input  logic [AW-1:0]     i_wb_addr,
  input  logic [XLEN-1:0]   i_wb_data,
  input  logic              i_ld_wr,
  input  logic [AW-1:0]     i_ld_addr,
  input  logic [XLEN-1:0]   i_ld_data,
  input  logic              i_ld_issue,
  input  logic [AW-1:0]     i_ld_rd,
  input  logic              i_flush,
  output logic [CW-1:0]     o_busy_cnt,
  output logic              o_issue_err
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy;

  regfile_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .ld_issue  (i_ld_issue),
    .ld_rd     (i_ld_rd),
    .ld_wr     (i_ld_wr),
    .ld_addr   (i_ld_addr),
    .flush     (i_flush),
    .busy      (busy),
    .busy_cnt  (o_busy_cnt),
    .issue_err (o_issue_err)
  );

  // Load write first, ALU writeback second: on a clash the later assignment
  // (i_wb) wins and the load data is dropped.
  always_comb begin
    regs_d = regs_q;
    if (i_ld_wr && (i_ld_addr != '0)) begin
      regs_d[i_ld_addr] = i_ld_data;
    end
    if (i_wb_wr && (i_wb_addr != '0)) begin
      regs_d[i_wb_addr] = i_wb_data;
    end
  end

  // NOTE: the storage array is reset on purpose: reset must clear register
  // contents, so it cannot map to a reset-less RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            bsy;
    o_rs_data = '0;
    o_rs_busy = '0;
    for (int p = 0; p < NRP; p++) begin
      addr = i_rs_addr[p*AW +: AW];
      data = regs_q[addr];
      bsy  = busy[addr];
`ifdef REGFILE_SB_BYPASS_EN
      if (i_ld_wr && (i_ld_addr == addr)) begin
        data = i_ld_data;
        bsy  = 1'b0;
      end
      if (i_wb_wr && (i_wb_addr == addr)) begin
        data = i_wb_data;
      end
`endif
      if (addr == '0) begin
        data = '0;
        bsy  = 1'b0;
      end
      o_rs_data[p*XLEN +: XLEN] = data;
      o_rs_busy[p]              = bsy;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb -- self-checking bench for regfile_sb with default parameters
// (XLEN=32, NREG=32, NRP=2). Directed scenarios plus a randomized run, all
// compared against a behavioural model of register contents and outstanding
// loads held in plain arrays. Build with REGFILE_SB_BYPASS_EN defined to
// exercise the forwarding variant.
// -----------------------------------------------------------------------------
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int AW   = 5;
  localparam int CW   = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NRP*AW-1:0] rs_addr = '0;
  logic [NRP*XLEN-1:0] rs_data;
  logic [NRP-1:0]    rs_busy;
  logic              wb_wr = 1'b0;
  logic [AW-1:0]     wb_addr = '0;
  logic [XLEN-1:0]   wb_data = '0;
  logic              ld_wr = 1'b0;
  logic [AW-1:0]     ld_addr = '0;
  logic [XLEN-1:0]   ld_data = '0;
  logic              ld_issue = 1'b0;
  logic [AW-1:0]     ld_rd = '0;
  logic              flush = 1'b0;
  logic [CW-1:0]     busy_cnt;
  logic              issue_err;

  int checks = 0;
  int errors = 0;

  // Reference model.
  logic [XLEN-1:0] m_regs [NREG];
  bit              m_busy [NREG];
  bit              m_err;

  regfile_sb #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRP  (NRP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rs_addr   (rs_addr),
    .o_rs_data   (rs_data),
    .o_rs_busy   (rs_busy),
    .i_wb_wr     (wb_wr),
    .i_wb_addr   (wb_addr),
    .i_wb_data   (wb_data),
    .i_ld_wr     (ld_wr),
    .i_ld_addr   (ld_addr),
    .i_ld_data   (ld_data),
    .i_ld_issue  (ld_issue),
    .i_ld_rd     (ld_rd),
    .i_flush     (flush),
    .o_busy_cnt  (busy_cnt),
    .o_issue_err (issue_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  // Expected combinational read for register a given the current drives.
  function automatic logic [XLEN-1:0] exp_data(int a);
    if (a == 0) return '0;
`ifdef REGFILE_SB_BYPASS_EN
    if (wb_wr && int'(wb_addr) == a) return wb_data;
    if (ld_wr && int'(ld_addr) == a) return ld_data;
`endif
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(int a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
    if (ld_wr && int'(ld_addr) == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  // Apply the clock-edge rules to the model using the current drives.
  task automatic model_edge();
    bit err = 1'b0;
    bit ret = ld_wr && (ld_addr != 0);
    if (ret && !(wb_wr && wb_addr == ld_addr)) m_regs[ld_addr] = ld_data;
    if (wb_wr && wb_addr != 0) m_regs[wb_addr] = wb_data;
    if (flush) begin
      for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    end else begin
      if (ld_issue && ld_rd != 0 && m_busy[ld_rd] && !(ret && ld_addr == ld_rd))
        err = 1'b1;
      if (ret) m_busy[ld_addr] = 1'b0;
      if (ld_issue && ld_rd != 0 && !err) m_busy[ld_rd] = 1'b1;
    end
    m_err = err;
  endtask

  // Model the edge, clock once, then drop all strobes.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    wb_wr = 1'b0;
    ld_wr = 1'b0;
    ld_issue = 1'b0;
    flush = 1'b0;
  endtask

  function automatic logic [XLEN-1:0] port_data(int p);
    return rs_data[p*XLEN +: XLEN];
  endfunction

  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rs_addr = {5'(t1), 5'(t0)};
    #1;
    checks++;
    if (busy_cnt !== '0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", busy_cnt);
    end
    checks++;
    if (issue_err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b want 0", issue_err);
    end
    checks++;
    if (port_data(0) !== '0 || rs_busy !== '0) begin
      errors++; $display("FAIL reset_read: data %h busy %b want 0/0", port_data(0), rs_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_rw();
    wb_wr = 1'b1; wb_addr = 5'(t0); wb_data = 32'h1234_5678;
    tick();
    rs_addr = {5'(zero), 5'(t0)};
    #1;
    checks++;
    if (port_data(0) !== 32'h1234_5678) begin
      errors++; $display("FAIL read_x5: got %h want 12345678", port_data(0));
    end
    wb_wr = 1'b1; wb_addr = 5'(zero); wb_data = 32'hFFFF_FFFF;
    tick();
    #1;
    checks++;
    if (port_data(1) !== '0 || rs_busy[1] !== 1'b0) begin
      errors++; $display("FAIL read_x0: got %h busy %b want 0/0", port_data(1), rs_busy[1]);
    end
  endtask

  task automatic test_write_collision();
    wb_wr = 1'b1; wb_addr = 5'(t2); wb_data = 32'hA;
    ld_wr = 1'b1; ld_addr = 5'(t2); ld_data = 32'hB;
    tick();
    rs_addr = {5'(t2), 5'(t2)};
    #1;
    checks++;
    if (port_data(0) !== 32'hA || port_data(1) !== 32'hA) begin
      errors++; $display("FAIL wb_wins: got %h/%h want a", port_data(0), port_data(1));
    end
    // Distinct registers written together.
    wb_wr = 1'b1; wb_addr = 5'(s0); wb_data = 32'h1111_0008;
    ld_wr = 1'b1; ld_addr = 5'(s1); ld_data = 32'h2222_0009;
    tick();
    rs_addr = {5'(s1), 5'(s0)};
    #1;
    checks++;
    if (port_data(0) !== 32'h1111_0008 || port_data(1) !== 32'h2222_0009) begin
      errors++; $display("FAIL dual_write: got %h/%h want 11110008/22220009",
                         port_data(0), port_data(1));
    end
  endtask

  task automatic test_load_busy();
    ld_issue = 1'b1; ld_rd = 5'(a0);
    tick();
    rs_addr = {5'(zero), 5'(a0)};
    #1;
    checks++;
    if (rs_busy[0] !== 1'b1 || busy_cnt !== 6'd1) begin
      errors++; $display("FAIL issue_x10: busy %b cnt %0d want 1/1", rs_busy[0], busy_cnt);
    end
    ld_wr = 1'b1; ld_addr = 5'(a0); ld_data = 32'h55;
    tick();
    #1;
    checks++;
    if (rs_busy[0] !== 1'b0 || busy_cnt !== 6'd0 || port_data(0) !== 32'h55) begin
      errors++; $display("FAIL return_x10: busy %b cnt %0d data %h want 0/0/55",
                         rs_busy[0], busy_cnt, port_data(0));
    end
    // Issue and return to the same register in one cycle: stays busy.
    ld_issue = 1'b1; ld_rd = 5'(a1);
    tick();
    ld_issue = 1'b1; ld_rd = 5'(a1);
    ld_wr = 1'b1; ld_addr = 5'(a1); ld_data = 32'h66;
    tick();
    rs_addr = {5'(zero), 5'(a1)};
    #1;
    checks++;
    if (rs_busy[0] !== 1'b1 || busy_cnt !== 6'd1 || issue_err !== 1'b0 ||
        port_data(0) !== 32'h66) begin
      errors++; $display("FAIL reissue_same: busy %b cnt %0d err %b data %h want 1/1/0/66",
                         rs_busy[0], busy_cnt, issue_err, port_data(0));
    end
    ld_wr = 1'b1; ld_addr = 5'(a1); ld_data = 32'h67;
    tick();
  endtask

  task automatic test_issue_err_flush();
    ld_issue = 1'b1; ld_rd = 5'(gp);
    tick();
    checks++;
    if (issue_err !== 1'b0 || busy_cnt !== 6'd1) begin
      errors++; $display("FAIL first_issue: err %b cnt %0d want 0/1", issue_err, busy_cnt);
    end
    ld_issue = 1'b1; ld_rd = 5'(gp);
    tick();
    checks++;
    if (issue_err !== 1'b1 || busy_cnt !== 6'd1) begin
      errors++; $display("FAIL dup_issue: err %b cnt %0d want 1/1", issue_err, busy_cnt);
    end
    tick();
    checks++;
    if (issue_err !== 1'b0) begin
      errors++; $display("FAIL err_pulse_len: err %b want 0", issue_err);
    end
    ld_issue = 1'b1; ld_rd = 5'(tp);
    tick();
    ld_issue = 1'b1; ld_rd = 5'(t1);
    tick();
    checks++;
    if (busy_cnt !== 6'd3) begin
      errors++; $display("FAIL three_busy: cnt %0d want 3", busy_cnt);
    end
    // Flush with a competing issue: flush wins.
    flush = 1'b1; ld_issue = 1'b1; ld_rd = 5'(s2);
    tick();
    rs_addr = {5'(s2), 5'(t1)};
    #1;
    checks++;
    if (busy_cnt !== 6'd0 || rs_busy !== 2'b00 || issue_err !== 1'b0) begin
      errors++; $display("FAIL flush: cnt %0d busy %b err %b want 0/00/0",
                         busy_cnt, rs_busy, issue_err);
    end
    rs_addr = {5'(t0), 5'(t2)};
    #1;
    checks++;
    if (port_data(0) !== 32'hA || port_data(1) !== 32'h1234_5678) begin
      errors++; $display("FAIL flush_keeps_data: got %h/%h want a/12345678",
                         port_data(0), port_data(1));
    end
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] want;
    wb_wr = 1'b1; wb_addr = 5'(s1); wb_data = 32'h1111;
    tick();
    rs_addr = {5'(zero), 5'(s1)};
    wb_wr = 1'b1; wb_addr = 5'(s1); wb_data = 32'hC0DE;
    #1;
`ifdef REGFILE_SB_BYPASS_EN
    want = 32'hC0DE;
`else
    want = 32'h1111;
`endif
    checks++;
    if (port_data(0) !== want) begin
      errors++; $display("FAIL same_cycle_read: got %h want %h", port_data(0), want);
    end
    tick();
    #1;
    checks++;
    if (port_data(0) !== 32'hC0DE) begin
      errors++; $display("FAIL next_cycle_read: got %h want c0de", port_data(0));
    end
    // Returning load: busy view during the return cycle.
    ld_issue = 1'b1; ld_rd = 5'(s1);
    tick();
    ld_wr = 1'b1; ld_addr = 5'(s1); ld_data = 32'hBEEF;
    #1;
    checks++;
    if (rs_busy[0] !== exp_busy(int'(s1)) || port_data(0) !== exp_data(int'(s1))) begin
      errors++; $display("FAIL return_view: busy %b data %h want %b/%h",
                         rs_busy[0], port_data(0), exp_busy(int'(s1)), exp_data(int'(s1)));
    end
    tick();
  endtask

  task automatic test_random();
    int a;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // Small address range so collisions and reissues are frequent.
      wb_wr    = ($urandom_range(0, 99) < 40);
      wb_addr  = AW'($urandom_range(0, 7));
      wb_data  = $urandom;
      ld_wr    = ($urandom_range(0, 99) < 40);
      ld_addr  = AW'($urandom_range(0, 7));
      ld_data  = $urandom;
      ld_issue = ($urandom_range(0, 99) < 40);
      ld_rd    = AW'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 99) < 4);
      rs_addr  = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      #1;
      for (int p = 0; p < NRP; p++) begin
        a = int'(rs_addr[p*AW +: AW]);
        checks++;
        if (port_data(p) !== exp_data(a) || rs_busy[p] !== exp_busy(a)) begin
          errors++;
          $display("FAIL rand_read c%0d p%0d x%0d: data %h busy %b want %h/%b",
                   cyc, p, a, port_data(p), rs_busy[p], exp_data(a), exp_busy(a));
        end
      end
      tick();
      checks++;
      if (issue_err !== m_err || int'(busy_cnt) != model_cnt()) begin
        errors++;
        $display("FAIL rand_state c%0d: err %b cnt %0d want %b/%0d",
                 cyc, issue_err, busy_cnt, m_err, model_cnt());
      end
    end
  endtask

  task automatic test_async_reset();
    flush = 1'b1;
    tick();
    wb_wr = 1'b1; wb_addr = 5'(t0); wb_data = 32'h1234_5678;
    tick();
    ld_issue = 1'b1; ld_rd = 5'(a1); tick();
    ld_issue = 1'b1; ld_rd = 5'(a2); tick();
    ld_issue = 1'b1; ld_rd = 5'(a3); tick();
    ld_issue = 1'b1; ld_rd = 5'(a4); tick();
    ld_issue = 1'b1; ld_rd = 5'(a4); tick();
    rs_addr = {5'(t0), 5'(a1)};
    #1;
    checks++;
    if (busy_cnt !== 6'd4 || issue_err !== 1'b1 || rs_busy[0] !== 1'b1) begin
      errors++; $display("FAIL pre_reset: cnt %0d err %b busy %b want 4/1/1",
                         busy_cnt, issue_err, rs_busy[0]);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (busy_cnt !== '0 || issue_err !== 1'b0 || rs_busy !== '0 || rs_data !== '0) begin
      errors++; $display("FAIL async_reset: cnt %0d err %b busy %b data %h want all 0",
                         busy_cnt, issue_err, rs_busy, rs_data);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ld_wr = 1'b1; ld_addr = 5'(a1); ld_data = 32'h77;
    tick();
    #1;
    checks++;
    if (port_data(0) !== 32'h77 || rs_busy[0] !== 1'b0 || busy_cnt !== '0) begin
      errors++; $display("FAIL late_return: data %h busy %b cnt %0d want 77/0/0",
                         port_data(0), rs_busy[0], busy_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_write_collision();
    test_load_busy();
    test_issue_err_flush();
    test_bypass();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register width in bits.
REQ-002 SHALL have parameter NREG, default 32, meaning register count (16 or 32); AW = $clog2(NREG).
REQ-003 SHALL have parameter NRP, default 2, meaning number of read ports (2..4).
REQ-004 SHALL have port clk  input  1  the single clock, rising-edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_rs_addr  input  NRP*AW  packed read addresses, port p at [p*AW +: AW].
REQ-007 SHALL have port o_rs_data  output  NRP*XLEN  packed read data, port p at [p*XLEN +: XLEN].
REQ-008 SHALL have port o_rs_busy  output  NRP  read port p's register has a load outstanding.
REQ-009 SHALL have ports i_wb_wr / i_wb_addr / i_wb_data  input  1/AW/XLEN  ALU writeback.
REQ-010 SHALL have ports i_ld_wr / i_ld_addr / i_ld_data  input  1/AW/XLEN  load-return writeback.
REQ-011 SHALL have ports i_ld_issue / i_ld_rd  input  1/AW  load issued to the bus; destination register.
REQ-012 SHALL have port i_flush  input  1  clears all busy bits.
REQ-013 SHALL have port o_busy_cnt  output  $clog2(NREG+1)  number of busy registers.
REQ-014 SHALL have port o_issue_err  output  1  registered one-cycle pulse on an illegal issue.

Function
REQ-015 SHALL return 0 and busy=0 on any read port addressing register 0; writes and issues to register 0 are ignored.
REQ-016 SHALL update a register at the clock edge when its write port is asserted; both write ports may write different registers in the same cycle.
REQ-017 SHALL let the i_wb write win and the i_ld write be dropped when both ports target the same register in the same cycle.
REQ-018 SHALL set busy[rd] at the edge on which i_ld_issue is asserted, and clear busy[a] at the edge on which i_ld_wr is asserted to a.
REQ-019 SHALL leave busy set when issue and load-return target the same register in the same cycle; the new load owns it.
REQ-020 SHALL, on i_ld_issue to an already-busy register, leave busy unchanged and assert o_issue_err for exactly the next cycle.
REQ-021 SHALL clear all busy bits on i_flush, with i_flush taking priority over a same-cycle i_ld_issue; register contents are unaffected.
REQ-022 SHALL keep o_busy_cnt as a registered counter equal to popcount(busy) after every edge, range 0..NREG-1.
REQ-023 SHALL produce o_rs_data and o_rs_busy combinationally from the addresses and current state.

Reset
REQ-024 SHALL, while rst is high, asynchronously clear all registers, all busy bits, o_busy_cnt and o_issue_err to 0.
REQ-025 SHALL discard any load outstanding when reset is applied; a later i_ld_wr updates data only.

Configuration
REQ-026 SHALL, with REGFILE_SB_BYPASS_EN defined, forward same-cycle write data to matching read ports (i_wb over i_ld), and report busy=0 for a register being returned by i_ld_wr that cycle.
REQ-027 SHALL, without REGFILE_SB_BYPASS_EN, return only the stored value and the registered busy bit, so write data is visible one cycle later.

Structure
REQ-028 SHALL take default XLEN/NREG/NRP constants and the ABI register-index enum (ra=1 .. t6=31) from the shared package regfile_pkg.
REQ-029 SHALL implement busy tracking, issue-error detection and the counter in sub-module regfile_scoreboard; storage and read muxing stay in regfile_sb.

Verification
REQ-030 SHALL cover: reset, then wb x5=0x1234_5678, then read x5 the next cycle -> 0x1234_5678; read x0 after writing 0xFFFF_FFFF to x0 -> 0.
REQ-031 SHALL cover: wb and ld both writing x7 in the same cycle (0xA, 0xB) -> x7=0xA.
REQ-032 SHALL cover: issue x10, then read x10 -> busy=1 and o_busy_cnt=1; ld return 0x55 -> busy=0, cnt=0, x10=0x55.
REQ-033 SHALL cover: issue x3 twice in consecutive cycles -> o_issue_err high for one cycle and cnt=1; then flush with 3 busy registers -> cnt=0.
REQ-034 SHALL cover, with REGFILE_SB_BYPASS_EN defined: wb x9=0xC0DE while reading x9 -> same-cycle read gives 0xC0DE; without the macro it gives the old value.
REQ-035 SHALL cover: rst asserted mid-cycle with 4 busy registers -> all outputs 0 immediately, without waiting for a clock edge.
